// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for a single-port on-chip memory with configurable read latency.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              r0_req,
  input  logic              r1_req,
  input  logic              r0_we,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r0_gnt,
  output logic              r1_gnt,
  output logic              r0_rvalid,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_rden,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int CNT_W = 2;

  state_t           state;
  logic             win;
  logic             lat_we;
  logic [CNT_W-1:0] wait_cnt;
  logic             sel;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_win;
  // On a tie the port that did not win last time goes first.
  assign sel = (r0_req & r1_req) ? ~last_win : r1_req;
`else
  assign sel = ~r0_req;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      win         <= 1'b0;
      lat_we      <= 1'b0;
      wait_cnt    <= '0;
      r0_gnt      <= 1'b0;
      r1_gnt      <= 1'b0;
      r0_rvalid   <= 1'b0;
      r1_rvalid   <= 1'b0;
      r0_rdata    <= '0;
      r1_rdata    <= '0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_rden    <= 1'b0;
      mem_wren    <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_win    <= 1'b1;
`endif
    end else begin
      r0_gnt    <= 1'b0;
      r1_gnt    <= 1'b0;
      mem_rden  <= 1'b0;
      mem_wren  <= 1'b0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (r0_req || r1_req) begin
            win         <= sel;
            lat_we      <= sel ? r1_we : r0_we;
            mem_address <= sel ? r1_addr : r0_addr;
            mem_data    <= sel ? r1_wdata : r0_wdata;
            mem_wren    <= sel ? r1_we : r0_we;
            mem_rden    <= sel ? ~r1_we : ~r0_we;
            r0_gnt      <= ~sel;
            r1_gnt      <= sel;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_win    <= sel;
`endif
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (lat_we) begin
            state <= IDLE;
          end else if (RD_LATENCY == 1) begin
            state <= RESP;
          end else begin
            wait_cnt <= CNT_W'(RD_LATENCY - 1);
            state    <= WAIT;
          end
        end
        // Stay RD_LATENCY-1 cycles so RESP lines up with mem_q becoming valid.
        WAIT: begin
          if (wait_cnt == CNT_W'(1)) state <= RESP;
          else                        wait_cnt <= wait_cnt - CNT_W'(1);
        end
        RESP: begin
          if (win) begin
            r1_rdata  <= mem_q;
            r1_rvalid <= 1'b1;
          end else begin
            r0_rdata  <= mem_q;
            r0_rvalid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
